// File: rtl/mips_regarb_pkg.sv
// rtl/mips_regarb_pkg.sv - shared constants and types for the register-file write arbiter
package mips_regarb_pkg;

   localparam int REG_ADDR_WIDTH = 5;
   localparam int REG_DATA_WIDTH = 32;

   typedef enum logic {
      REQ_ALU = 1'b0,
      REQ_MEM = 1'b1
   } req_id_e;

   typedef struct packed {
      logic [REG_ADDR_WIDTH-1:0] reg_addr;
      logic [REG_DATA_WIDTH-1:0] data;
   } wr_req_t;

endpackage

// File: rtl/mips_regarb_fifo.sv
// rtl/mips_regarb_fifo.sv - per-requester write FIFO with per-slot valid/address taps
module mips_regarb_fifo
   import mips_regarb_pkg::*;
#(
   parameter int DEPTH      = 2,
   parameter int DATA_WIDTH = REG_DATA_WIDTH,
   parameter int ADDR_WIDTH = REG_ADDR_WIDTH
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             push,
   input  logic [ADDR_WIDTH-1:0]            push_reg,
   input  logic [DATA_WIDTH-1:0]            push_data,
   input  logic                             pop,
   output logic [ADDR_WIDTH-1:0]            head_reg,
   output logic [DATA_WIDTH-1:0]            head_data,
   output logic                             full,
   output logic                             empty,
   output logic [DEPTH-1:0]                 entry_valid,
   output logic [DEPTH-1:0][ADDR_WIDTH-1:0] entry_reg
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [ADDR_WIDTH-1:0] reg_mem  [DEPTH];
   logic [DATA_WIDTH-1:0] data_mem [DEPTH];
   logic [PTR_W-1:0]      rd_ptr;
   logic [PTR_W-1:0]      wr_ptr;
   logic [DEPTH-1:0]      valid_q;
   logic                  do_push;
   logic                  do_pop;

   // Occupancy is tracked per slot; the valid bits double as the hazard taps.
   assign full    = &valid_q;
   assign empty   = ~|valid_q;
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         valid_q <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         for (int i = 0; i < DEPTH; i++) begin
            if (do_push && wr_ptr == PTR_W'(i))
               valid_q[i] <= 1'b1;
            else if (do_pop && rd_ptr == PTR_W'(i))
               valid_q[i] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         reg_mem[wr_ptr]  <= push_reg;
         data_mem[wr_ptr] <= push_data;
      end
   end

   assign head_reg    = reg_mem[rd_ptr];
   assign head_data   = data_mem[rd_ptr];
   assign entry_valid = valid_q;

   always_comb begin
      for (int i = 0; i < DEPTH; i++)
         entry_reg[i] = reg_mem[i];
   end

endmodule

// File: rtl/mips_regfile_write_arbiter.sv
// rtl/mips_regfile_write_arbiter.sv - shares the register-file write port between ALU and load writeback
// MIPS_REGARB_ROUND_ROBIN_EN selects round-robin arbitration instead of fixed MEM-over-ALU priority.
module mips_regfile_write_arbiter
   import mips_regarb_pkg::*;
#(
   parameter int DEPTH      = 2,
   parameter int DATA_WIDTH = REG_DATA_WIDTH,
   parameter int ADDR_WIDTH = REG_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  alu_req_valid,
   output logic                  alu_req_ready,
   input  logic [ADDR_WIDTH-1:0] alu_req_reg,
   input  logic [DATA_WIDTH-1:0] alu_req_data,
   input  logic                  mem_req_valid,
   output logic                  mem_req_ready,
   input  logic [ADDR_WIDTH-1:0] mem_req_reg,
   input  logic [DATA_WIDTH-1:0] mem_req_data,
   output logic [ADDR_WIDTH-1:0] write_reg,
   output logic [DATA_WIDTH-1:0] write_data,
   output logic                  signal_reg_write,
   output logic [31:0]           pending_mask
);

   logic                             alu_full, alu_empty, mem_full, mem_empty;
   logic                             alu_push, mem_push, alu_pop, mem_pop;
   logic [ADDR_WIDTH-1:0]            alu_head_reg, mem_head_reg;
   logic [DATA_WIDTH-1:0]            alu_head_data, mem_head_data;
   logic [DEPTH-1:0]                 alu_entry_valid, mem_entry_valid;
   logic [DEPTH-1:0][ADDR_WIDTH-1:0] alu_entry_reg, mem_entry_reg;
   logic                             any_req;
   logic                             prefer_mem;
   req_id_e                          grant;

   // Register 0 is hardwired; its writes complete the handshake but never queue.
   assign alu_req_ready = !alu_full && !reset;
   assign mem_req_ready = !mem_full && !reset;
   assign alu_push      = alu_req_valid && alu_req_ready && (alu_req_reg != '0);
   assign mem_push      = mem_req_valid && mem_req_ready && (mem_req_reg != '0);

   mips_regarb_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_alu_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (alu_push),
      .push_reg   (alu_req_reg),
      .push_data  (alu_req_data),
      .pop        (alu_pop),
      .head_reg   (alu_head_reg),
      .head_data  (alu_head_data),
      .full       (alu_full),
      .empty      (alu_empty),
      .entry_valid(alu_entry_valid),
      .entry_reg  (alu_entry_reg)
   );

   mips_regarb_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_mem_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (mem_push),
      .push_reg   (mem_req_reg),
      .push_data  (mem_req_data),
      .pop        (mem_pop),
      .head_reg   (mem_head_reg),
      .head_data  (mem_head_data),
      .full       (mem_full),
      .empty      (mem_empty),
      .entry_valid(mem_entry_valid),
      .entry_reg  (mem_entry_reg)
   );

`ifdef MIPS_REGARB_ROUND_ROBIN_EN
   req_id_e last_grant;

   // Every grant, contended or not, moves the flag so ties go to the other side.
   always_ff @(posedge clk) begin
      if (reset)
         last_grant <= REQ_ALU;
      else if (any_req)
         last_grant <= grant;
   end

   assign prefer_mem = (last_grant == REQ_ALU);
`else
   assign prefer_mem = 1'b1;
`endif

   assign any_req = !alu_empty || !mem_empty;
   assign grant   = (!mem_empty && (alu_empty || prefer_mem)) ? REQ_MEM : REQ_ALU;
   assign mem_pop = any_req && (grant == REQ_MEM);
   assign alu_pop = any_req && (grant == REQ_ALU);

   always_ff @(posedge clk) begin
      if (reset) begin
         signal_reg_write <= 1'b0;
         write_reg        <= '0;
         write_data       <= '0;
      end else if (any_req) begin
         signal_reg_write <= 1'b1;
         write_reg        <= (grant == REQ_MEM) ? mem_head_reg  : alu_head_reg;
         write_data       <= (grant == REQ_MEM) ? mem_head_data : alu_head_data;
      end else begin
         signal_reg_write <= 1'b0;
      end
   end

   // Queued entries plus the write currently on the port are all still in flight.
   always_comb begin
      pending_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (alu_entry_valid[i]) pending_mask[alu_entry_reg[i]] = 1'b1;
         if (mem_entry_valid[i]) pending_mask[mem_entry_reg[i]] = 1'b1;
      end
      if (signal_reg_write) pending_mask[write_reg] = 1'b1;
   end

endmodule
